// File: rtl/csla_pipe_adder_if.sv
// Valid/ready operand and result channels of the pipelined carry-select adder.
// The producer/consumer side takes the master modport, the adder takes the slave modport.
interface csla_pipe_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/csla_pipe_adder.sv
// Two-stage carry-select adder/subtractor: stage 1 precomputes every block for both
// carry-ins, stage 2 resolves the block carry chain with select muxes.
module csla_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input logic              clk,
  input logic              rst_n,
  csla_pipe_adder_if.slave bus
);
  localparam int NB = WIDTH / BLOCK;

  generate
    if (WIDTH < 2 || (WIDTH % BLOCK) != 0) begin : g_bad_params
      $error("csla_pipe_adder: WIDTH must be >= 2 and a multiple of BLOCK");
    end
  endgenerate

  // Operand preparation and per-block dual sums.
  logic [WIDTH-1:0]        w_b_eff;
  logic                    w_cin_eff;
  logic [NB-1:0][BLOCK:0]  w_p0;
  logic [NB-1:0][BLOCK:0]  w_p1;

  assign w_b_eff   = bus.sub ? ~bus.b : bus.b;
  assign w_cin_eff = bus.sub | bus.cin;

  for (genvar k = 0; k < NB; k++) begin : g_blk
    assign w_p0[k] = {1'b0, bus.a[k*BLOCK +: BLOCK]} + {1'b0, w_b_eff[k*BLOCK +: BLOCK]};
    assign w_p1[k] = {1'b0, bus.a[k*BLOCK +: BLOCK]} + {1'b0, w_b_eff[k*BLOCK +: BLOCK]}
                   + {{BLOCK{1'b0}}, 1'b1};
  end

  // Stage 1 state.
  logic [NB-1:0][BLOCK-1:0] r_s0;
  logic [NB-1:0][BLOCK-1:0] r_s1;
  logic [NB-1:0]            r_c0;
  logic [NB-1:0]            r_c1;
  logic                     r_s1_v;
  logic                     r_cin_eff;
  logic                     r_a_msb;
  logic                     r_b_msb;

  // Stage 2 state.
  logic [WIDTH-1:0]         r_sum;
  logic                     r_cout;
  logic                     r_ovf;
  logic                     r_out_valid;

  // Flow control; in_ready depends only on out_ready, rst_n and registered state.
  logic w_s2_adv;
  logic w_s1_adv;
  logic w_in_ready;
  logic w_accept;
  logic w_s2_load;

  assign w_s2_adv   = !r_out_valid || bus.out_ready;
  assign w_s1_adv   = !r_s1_v || w_s2_adv;
  assign w_in_ready = rst_n && w_s1_adv;
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_s2_load  = r_s1_v && w_s2_adv;

  // Block carry chain: NB select muxes in series.
  logic [NB:0]      w_carry;
  logic [WIDTH-1:0] w_sum;
  logic             w_ovf;

  // NOTE: every variable written here gets a default first, so no latch can be inferred.
  always_comb begin
    w_carry    = '0;
    w_sum      = '0;
    w_carry[0] = r_cin_eff;
    for (int i = 0; i < NB; i++) begin
      w_sum[i*BLOCK +: BLOCK] = w_carry[i] ? r_s1[i] : r_s0[i];
      w_carry[i+1]            = w_carry[i] ? r_c1[i] : r_c0[i];
    end
  end

  assign w_ovf = (r_a_msb == r_b_msb) && (w_sum[WIDTH-1] != r_a_msb);

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  // Stage-1 payload is reset too, so a flushed pipeline never exposes stale operands.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_v    <= 1'b0;
      r_s0      <= '0;
      r_s1      <= '0;
      r_c0      <= '0;
      r_c1      <= '0;
      r_cin_eff <= 1'b0;
      r_a_msb   <= 1'b0;
      r_b_msb   <= 1'b0;
    end else if (w_accept) begin
      r_s1_v    <= 1'b1;
      r_cin_eff <= w_cin_eff;
      r_a_msb   <= bus.a[WIDTH-1];
      r_b_msb   <= w_b_eff[WIDTH-1];
      for (int i = 0; i < NB; i++) begin
        r_s0[i] <= w_p0[i][BLOCK-1:0];
        r_c0[i] <= w_p0[i][BLOCK];
        r_s1[i] <= w_p1[i][BLOCK-1:0];
        r_c1[i] <= w_p1[i][BLOCK];
      end
    end else if (w_s2_adv) begin
      r_s1_v <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
    end else if (w_s2_load) begin
      r_out_valid <= 1'b1;
      r_sum       <= w_sum;
      r_cout      <= w_carry[NB];
      r_ovf       <= w_ovf;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_csla_pipe_adder.sv
// Directed and scoreboarded bench for csla_pipe_adder at WIDTH=16, BLOCK=4.
module tb_csla_pipe_adder;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  logic [17:0] sb_q[$];

  csla_pipe_adder_if #(.WIDTH(16)) bus ();

  csla_pipe_adder #(.WIDTH(16), .BLOCK(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result packed as {ovf, cout, sum}.
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic cin, input logic sub);
    logic [15:0] be;
    logic        ce;
    logic [16:0] r;
    be = sub ? ~b : b;
    ce = sub ? 1'b1 : cin;
    r  = {1'b0, a} + {1'b0, be} + {16'd0, ce};
    return {(a[15] == be[15]) && (r[15] != a[15]), r[16], r[15:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    bus.in_valid = 1'b1;
    bus.a        = 16'h1234;
    bus.b        = 16'h4321;
    bus.cin      = 1'b1;
    bus.sub      = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.sum !== 16'h0000 || bus.cout !== 1'b0 ||
        bus.ovf !== 1'b0 || bus.in_ready !== 1'b0)
      $display("FAIL reset_state: got v=%b sum=%h c=%b o=%b rdy=%b required 0 0000 0 0 0",
               bus.out_valid, bus.sum, bus.cout, bus.ovf, bus.in_ready);
    if (bus.out_valid !== 1'b0 || bus.sum !== 16'h0000 || bus.cout !== 1'b0 ||
        bus.ovf !== 1'b0 || bus.in_ready !== 1'b0) n_fail++;
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b required 1", bus.in_ready);
    end
    step();
  endtask

  // One isolated operation; verifies the two-cycle latency and the result.
  task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic sub, input logic [15:0] e_sum,
                        input logic e_cout, input logic e_ovf);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.a = a; bus.b = b; bus.cin = cin; bus.sub = sub;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_in_ready: got %b required 1", name, bus.in_ready);
    end
    step();
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_latency_early: out_valid got %b required 0", name, bus.out_valid);
    end
    step();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.sum !== e_sum || bus.cout !== e_cout || bus.ovf !== e_ovf) begin
      n_fail++;
      $display("FAIL %s: got v=%b sum=%h c=%b o=%b required v=1 sum=%h c=%b o=%b",
               name, bus.out_valid, bus.sum, bus.cout, bus.ovf, e_sum, e_cout, e_ovf);
    end
    step();
  endtask

  task automatic test_add();
    run_op("add_ffff_1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("add_7fff_1", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("add_cin",    16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
  endtask

  task automatic test_sub();
    run_op("sub_5_7",       16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub_8000_1",    16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_op("sub_5_7_cin",   16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub_8000_1_cin", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
  endtask

  task automatic test_back_pressure();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.cin = 1'b0; bus.sub = 1'b0;
    bus.a = 16'h0001; bus.b = 16'h0001;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_accept1: in_ready got %b required 1", bus.in_ready);
    end
    step();
    bus.a = 16'h0002; bus.b = 16'h0002;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_accept2: in_ready=%b out_valid=%b required 1 0", bus.in_ready, bus.out_valid);
    end
    step();
    bus.a = 16'h0003; bus.b = 16'h0003;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.sum !== 16'h0002) begin
        n_fail++;
        $display("FAIL bp_hold%0d: in_ready=%b out_valid=%b sum=%h required 0 1 0002",
                 i, bus.in_ready, bus.out_valid, bus.sum);
      end
      if (i < 3) step();
    end
    bus.out_ready = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_fill_drain: in_ready got %b required 1", bus.in_ready);
    end
    step();
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.sum !== 16'h0004) begin
      n_fail++;
      $display("FAIL bp_drain2: out_valid=%b sum=%h required 1 0004", bus.out_valid, bus.sum);
    end
    step();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.sum !== 16'h0006) begin
      n_fail++;
      $display("FAIL bp_drain3: out_valid=%b sum=%h required 1 0006", bus.out_valid, bus.sum);
    end
    step();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_no_dup: out_valid got %b required 0", bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int          received;
    int          iters;
    logic [17:0] obs;
    logic [17:0] exp;
    sb_q.delete();
    received      = 0;
    iters         = 0;
    bus.out_ready = 1'b1;
    while (received < 100 && iters < 200) begin
      bus.in_valid = (iters < 100);
      bus.a   = 16'($urandom);
      bus.b   = 16'($urandom);
      bus.cin = 1'($urandom);
      bus.sub = 1'($urandom);
      #1;
      if (bus.out_valid) begin
        obs = {bus.ovf, bus.cout, bus.sum};
        n_checks++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL stream_spurious: got %h with empty scoreboard", obs);
        end else begin
          exp = sb_q.pop_front();
          if (obs !== exp) begin
            n_fail++;
            $display("FAIL stream_result%0d: got %h required %h", received, obs, exp);
          end
        end
        received++;
      end
      if (bus.in_valid && bus.in_ready)
        sb_q.push_back(model(bus.a, bus.b, bus.cin, bus.sub));
      iters++;
      step();
    end
    bus.in_valid = 1'b0;
    n_checks++;
    if (received != 100 || iters != 102) begin
      n_fail++;
      $display("FAIL stream_throughput: got %0d results in %0d cycles required 100 in 102",
               received, iters);
    end
  endtask

  task automatic test_random_stalls();
    logic [17:0] obs;
    logic [17:0] exp;
    logic [17:0] held;
    bit          held_v;
    int          guard;
    sb_q.delete();
    held_v = 1'b0;
    held   = '0;
    for (int t = 0; t < 300; t++) begin
      if (t == 150) begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'($urandom);
        bus.out_ready = 1'b0;
        step();
        rst_n = 1'b1;
        sb_q.delete();
        held_v = 1'b0;
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL midreset_flush: out_valid=%b in_ready=%b required 0 1",
                   bus.out_valid, bus.in_ready);
        end
      end
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.out_ready = ($urandom_range(0, 9) < 6);
      bus.a   = 16'($urandom);
      bus.b   = 16'($urandom);
      bus.cin = 1'($urandom);
      bus.sub = 1'($urandom);
      #1;
      obs = {bus.ovf, bus.cout, bus.sum};
      if (held_v) begin
        n_checks++;
        if (bus.out_valid !== 1'b1 || obs !== held) begin
          n_fail++;
          $display("FAIL stall_hold t=%0d: got v=%b %h required v=1 %h", t, bus.out_valid, obs, held);
        end
      end
      held_v = bus.out_valid && !bus.out_ready;
      held   = obs;
      if (bus.out_valid && bus.out_ready) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL random_spurious t=%0d: got %h with empty scoreboard", t, obs);
        end else begin
          exp = sb_q.pop_front();
          if (obs !== exp) begin
            n_fail++;
            $display("FAIL random_result t=%0d: got %h required %h", t, obs, exp);
          end
        end
      end
      if (bus.in_valid && bus.in_ready)
        sb_q.push_back(model(bus.a, bus.b, bus.cin, bus.sub));
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    guard = 0;
    while (sb_q.size() != 0 && guard < 10) begin
      #1;
      if (bus.out_valid) begin
        obs = {bus.ovf, bus.cout, bus.sum};
        exp = sb_q.pop_front();
        n_checks++;
        if (obs !== exp) begin
          n_fail++;
          $display("FAIL random_drain: got %h required %h", obs, exp);
        end
      end
      guard++;
      step();
    end
    #1;
    n_checks++;
    if (sb_q.size() != 0 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL random_final: %0d beats outstanding, out_valid=%b required 0 0",
               sb_q.size(), bus.out_valid);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_add();
    test_sub();
    test_back_pressure();
    test_back_to_back();
    test_random_stalls();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
